// File: rtl/pipeline_display_driver_pkg.sv
// Shared display definitions for the pipeline display driver.
// Holds the active-low seven-segment codes (segments a..g = bits 6..0),
// the blank/anode-off patterns and the digit-group boundaries that split
// the eight-digit display into the PC group (7..4) and the write-data
// group (3..0).
package display_defs;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_0 = 7'b0000001;
   localparam seg_t SEG_1 = 7'b1001111;
   localparam seg_t SEG_2 = 7'b0010010;
   localparam seg_t SEG_3 = 7'b0000110;
   localparam seg_t SEG_4 = 7'b1001100;
   localparam seg_t SEG_5 = 7'b0100100;
   localparam seg_t SEG_6 = 7'b0100000;
   localparam seg_t SEG_7 = 7'b0001111;
   localparam seg_t SEG_8 = 7'b0000000;
   localparam seg_t SEG_9 = 7'b0000100;
   localparam seg_t SEG_A = 7'b0001000;
   localparam seg_t SEG_B = 7'b1100000;
   localparam seg_t SEG_C = 7'b0110001;
   localparam seg_t SEG_D = 7'b1000010;
   localparam seg_t SEG_E = 7'b0110000;
   localparam seg_t SEG_F = 7'b0111000;

   localparam seg_t       SEG_BLANK = 7'h7F;
   localparam logic [7:0] AN_OFF    = 8'hFF;

   // Lowest (least significant) digit index of each 4-digit group.
   localparam logic [2:0] PC_DIGIT_LO = 3'd4;
   localparam logic [2:0] WD_DIGIT_LO = 3'd0;

endpackage

// File: rtl/pipeline_display_driver_hex_to_7seg.sv
// hex_to_7seg: combinational 4-bit to active-low seven-segment decoder.
// Ports:
//   nibble  in  4  hex value to display
//   seg     out 7  segments a..g on bits 6..0, active-low
module hex_to_7seg
   import display_defs::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (nibble)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
      endcase
   end

endmodule

// File: rtl/pipeline_display_driver.sv
// pipeline_display_driver: latches the low 16 bits of the CPU PC and
// write-back data on a capture strobe and scans them as eight hex digits
// onto a common-anode seven-segment display (PC on digits 7..4, write
// data on digits 3..0). Each digit slot starts with an all-anodes-off
// window to suppress ghosting.
// Optional feature macro: DISPLAY_LZB_EN enables leading-zero blanking
// within each 4-digit group (group-LSB digits 4 and 0 always display).
// Ports:
//   Clk           in  1   clock, rising edge
//   Reset         in  1   asynchronous active-high reset
//   PCResult      in  32  CPU program counter (bits 15:0 used)
//   WriteDataReg  in  32  CPU write-back data (bits 15:0 used)
//   Capture       in  1   load pulse for the capture registers
//   Freeze        in  1   holds the captured values, overrides Capture
//   out_7         out 7   segments a..g, active-low
//   en_out        out 8   digit anodes, active-low, bit i = digit i
//   dp            out 1   decimal point, active-low
module pipeline_display_driver
   import display_defs::*;
#(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
)
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] PCResult,
   input  logic [31:0] WriteDataReg,
   input  logic        Capture,
   input  logic        Freeze,
   output logic [6:0]  out_7,
   output logic [7:0]  en_out,
   output logic        dp
);

   localparam int              CntW     = $clog2(REFRESH_DIV);
   localparam logic [CntW-1:0] CntLast  = CntW'(REFRESH_DIV - 1);
   localparam logic [CntW-1:0] BlankLim = CntW'(BLANK_CYCLES);

   logic [15:0]     pcQ;
   logic [15:0]     wdQ;
   logic [CntW-1:0] cnt;
   logic [2:0]      idx;
   logic [3:0]      nibble;
   logic [6:0]      segCode;
   logic [7:0]      anodeSel;
   logic            digitBlank;
   logic            unusedHi;

   assign unusedHi = ^{PCResult[31:16], WriteDataReg[31:16]};

   // idx[2] picks the group; idx[1:0] is the digit position inside it.
   always_comb begin
      nibble   = idx[2] ? pcQ[{idx[1:0], 2'b00} +: 4] : wdQ[{idx[1:0], 2'b00} +: 4];
      anodeSel = ~(8'd1 << idx);
   end

`ifdef DISPLAY_LZB_EN
   logic [15:0] groupVal;
   logic [2:0]  groupLo;
   logic [2:0]  groupPos;

   // A digit is a leading zero when it and every higher digit of its
   // group are zero, i.e. the group value shifted down to it is zero.
   always_comb begin
      groupVal   = idx[2] ? pcQ : wdQ;
      groupLo    = idx[2] ? PC_DIGIT_LO : WD_DIGIT_LO;
      groupPos   = idx - groupLo;
      digitBlank = (idx != groupLo) && ((groupVal >> {groupPos, 2'b00}) == 16'd0);
   end
`else
   assign digitBlank = 1'b0;
`endif

   hex_to_7seg uHexDecode (
      .nibble (nibble),
      .seg    (segCode)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pcQ    <= 16'd0;
         wdQ    <= 16'd0;
         cnt    <= '0;
         idx    <= 3'd0;
         en_out <= AN_OFF;
         out_7  <= SEG_BLANK;
         dp     <= 1'b1;
      end else begin
         if (Capture && !Freeze) begin
            pcQ <= PCResult[15:0];
            wdQ <= WriteDataReg[15:0];
         end

         if (cnt == CntLast) begin
            cnt <= '0;
            idx <= idx + 3'd1;
         end else begin
            cnt <= cnt + 1'b1;
         end

         en_out <= (cnt < BlankLim) ? AN_OFF : anodeSel;
         out_7  <= digitBlank ? SEG_BLANK : segCode;
         dp     <= (idx == PC_DIGIT_LO) ? 1'b0 : 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_display_driver.sv
module tb_pipeline_display_driver;

   localparam int RDIV  = 4;
   localparam int BLANK = 1;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Capture;
   logic        Freeze;
   logic [31:0] PCResult;
   logic [31:0] WriteDataReg;
   logic [6:0]  out_7;
   logic [7:0]  en_out;
   logic        dp;

   int nChecks = 0;
   int nFail   = 0;

   always #5 Clk = ~Clk;

   pipeline_display_driver #(.REFRESH_DIV(RDIV), .BLANK_CYCLES(BLANK)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .PCResult     (PCResult),
      .WriteDataReg (WriteDataReg),
      .Capture      (Capture),
      .Freeze       (Freeze),
      .out_7        (out_7),
      .en_out       (en_out),
      .dp           (dp)
   );

   logic [6:0] segTab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   // Reference model: cyc counts clock edges since reset; the output after
   // an edge shows the scan position implied by the edges before it.
   int unsigned cyc;
   logic [15:0] mPc, mWd;
   logic [7:0]  expEn;
   logic [6:0]  expSeg;
   logic        expDp;

   function automatic logic [15:0] predict(int unsigned c, logic [15:0] p, logic [15:0] w);
      int unsigned digit, pos;
      logic [31:0] both;
      logic [3:0]  nib;
      logic [7:0]  en;
      logic [6:0]  seg;
      pos   = c % RDIV;
      digit = (c / RDIV) % 8;
      en    = (pos < BLANK) ? 8'hFF : ~(8'd1 << digit);
      both  = {p, w};
      nib   = 4'(both >> (4 * digit));
      seg   = segTab[nib];
`ifdef DISPLAY_LZB_EN
      begin
         logic [15:0] grp;
         grp = (digit >= 4) ? p : w;
         if ((digit % 4) != 0 && (grp >> (4 * (digit % 4))) == 16'd0) seg = 7'h7F;
      end
`endif
      return {en, seg, (digit == 4) ? 1'b0 : 1'b1};
   endfunction

   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cyc    <= 0;
         mPc    <= 16'd0;
         mWd    <= 16'd0;
         expEn  <= 8'hFF;
         expSeg <= 7'h7F;
         expDp  <= 1'b1;
      end else begin
         {expEn, expSeg, expDp} <= predict(cyc, mPc, mWd);
         cyc <= cyc + 1;
         if (Capture && !Freeze) begin
            mPc <= PCResult[15:0];
            mWd <= WriteDataReg[15:0];
         end
      end
   end

   task automatic test_reset;
      Reset = 1'b1; Capture = 1'b0; Freeze = 1'b0; PCResult = '0; WriteDataReg = '0;
      repeat (3) begin
         @(negedge Clk);
         nChecks++;
         if (en_out !== 8'hFF || out_7 !== 7'h7F || dp !== 1'b1) begin
            nFail++;
            $display("FAIL reset_hold: en=%h seg=%b dp=%b want en=ff seg=1111111 dp=1", en_out, out_7, dp);
         end
      end
      Reset = 1'b0;
      @(negedge Clk);
      nChecks++;
      if (en_out !== 8'hFF) begin
         nFail++;
         $display("FAIL reset_first_blank: en=%h want ff", en_out);
      end
      @(negedge Clk);
      nChecks++;
      if (en_out !== 8'hFE) begin
         nFail++;
         $display("FAIL reset_first_slot: en=%h want fe", en_out);
      end
   endtask

   task automatic test_capture_scan;
      logic [31:0] shown;
      logic [7:0]  seen;
      int          active, d;
      shown = 32'hA418_00F1;
      seen = 8'h00; active = 0;
      PCResult = 32'h0000_A418; WriteDataReg = 32'h0000_00F1; Capture = 1'b1;
      @(negedge Clk);
      Capture = 1'b0;
      repeat (32) begin
         @(negedge Clk);
         nChecks++;
         if (en_out !== expEn || out_7 !== expSeg || dp !== expDp) begin
            nFail++;
            $display("FAIL scan_model: en=%h seg=%b dp=%b want en=%h seg=%b dp=%b", en_out, out_7, dp, expEn, expSeg, expDp);
         end
         if (en_out !== 8'hFF) begin
            active++;
            d = 0;
            for (int i = 0; i < 8; i++) if (en_out[i] == 1'b0) d = i;
            seen[d] = 1'b1;
            nChecks++;
            if ($countones(~en_out) != 1) begin
               nFail++;
               $display("FAIL scan_onehot: en=%h want exactly one low anode", en_out);
            end
            nChecks++;
            if (dp !== ((d == 4) ? 1'b0 : 1'b1)) begin
               nFail++;
               $display("FAIL scan_dp: digit %0d dp=%b want %b", d, dp, (d == 4) ? 1'b0 : 1'b1);
            end
`ifndef DISPLAY_LZB_EN
            nChecks++;
            if (out_7 !== segTab[shown[4*d +: 4]]) begin
               nFail++;
               $display("FAIL scan_digit: digit %0d seg=%b want %b", d, out_7, segTab[shown[4*d +: 4]]);
            end
`endif
         end
      end
      nChecks++;
      if (active != 24 || seen !== 8'hFF) begin
         nFail++;
         $display("FAIL scan_slots: active=%0d seen=%h want active=24 seen=ff", active, seen);
      end
   endtask

   task automatic test_freeze;
      Freeze = 1'b1;
      PCResult = 32'h0000_1234; WriteDataReg = 32'h0000_5678; Capture = 1'b1;
      @(negedge Clk);
      Capture = 1'b0;
      repeat (32) begin
         @(negedge Clk);
         nChecks++;
         if (en_out !== expEn || out_7 !== expSeg || dp !== expDp) begin
            nFail++;
            $display("FAIL freeze_hold: en=%h seg=%b dp=%b want en=%h seg=%b dp=%b", en_out, out_7, dp, expEn, expSeg, expDp);
         end
      end
      Freeze = 1'b0; Capture = 1'b1;
      @(negedge Clk);
      Capture = 1'b0;
      repeat (32) begin
         @(negedge Clk);
         nChecks++;
         if (en_out !== expEn || out_7 !== expSeg || dp !== expDp) begin
            nFail++;
            $display("FAIL freeze_release: en=%h seg=%b dp=%b want en=%h seg=%b dp=%b", en_out, out_7, dp, expEn, expSeg, expDp);
         end
      end
   endtask

   task automatic test_tc_capture;
      int n;
      n = 0;
      while ((cyc % 32) != 15 && n < 100) begin @(negedge Clk); n++; end
      nChecks++;
      if ((cyc % 32) != 15) begin
         nFail++;
         $display("FAIL tc_wait: timeout reaching idx3/cnt3, cyc=%0d", cyc);
      end
      WriteDataReg = 32'h0000_0008; Capture = 1'b1;
      @(negedge Clk);
      Capture = 1'b0;
      n = 0;
      while ((cyc % 32) != 2 && n < 100) begin
         @(negedge Clk); n++;
         nChecks++;
         if (en_out !== expEn || out_7 !== expSeg || dp !== expDp) begin
            nFail++;
            $display("FAIL tc_model: en=%h seg=%b dp=%b want en=%h seg=%b dp=%b", en_out, out_7, dp, expEn, expSeg, expDp);
         end
      end
      nChecks++;
      if (en_out !== 8'hFE || out_7 !== 7'b0000000) begin
         nFail++;
         $display("FAIL tc_digit0: en=%h seg=%b want en=fe seg=0000000", en_out, out_7);
      end
   endtask

   task automatic test_async_reset;
      int n;
      n = 0;
      while ((cyc % 32) != 23 && n < 100) begin @(negedge Clk); n++; end
      nChecks++;
      if (en_out !== 8'hDF) begin
         nFail++;
         $display("FAIL areset_pre: en=%h want df (digit 5 active)", en_out);
      end
      #2 Reset = 1'b1;
      #1;
      nChecks++;
      if (en_out !== 8'hFF || out_7 !== 7'h7F || dp !== 1'b1 || dut.pcQ !== 16'h0000) begin
         nFail++;
         $display("FAIL areset_async: en=%h seg=%b dp=%b pc=%h want en=ff seg=1111111 dp=1 pc=0000", en_out, out_7, dp, dut.pcQ);
      end
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      nChecks++;
      if (en_out !== 8'hFF) begin
         nFail++;
         $display("FAIL areset_blank: en=%h want ff", en_out);
      end
      @(negedge Clk);
      nChecks++;
      if (en_out !== 8'hFE || out_7 !== segTab[0]) begin
         nFail++;
         $display("FAIL areset_resume: en=%h seg=%b want en=fe seg=%b", en_out, out_7, segTab[0]);
      end
   endtask

   task automatic test_random;
      repeat (300) begin
         @(negedge Clk);
         nChecks++;
         if (en_out !== expEn || out_7 !== expSeg || dp !== expDp) begin
            nFail++;
            $display("FAIL random: cyc=%0d en=%h seg=%b dp=%b want en=%h seg=%b dp=%b", cyc, en_out, out_7, dp, expEn, expSeg, expDp);
         end
         Capture      = ($urandom_range(0, 3) == 0);
         Freeze       = ($urandom_range(0, 3) == 0);
         PCResult     = $urandom;
         WriteDataReg = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000_00FF) : $urandom;
      end
      Capture = 1'b0; Freeze = 1'b0;
   endtask

`ifdef DISPLAY_LZB_EN
   task automatic test_lzb;
      logic [6:0] want [8];
      int d;
      want = '{segTab[1], segTab[15], 7'h7F, 7'h7F, segTab[0], 7'h7F, 7'h7F, 7'h7F};
      PCResult = 32'h0; WriteDataReg = 32'h0000_00F1; Capture = 1'b1;
      @(negedge Clk);
      Capture = 1'b0;
      repeat (32) begin
         @(negedge Clk);
         nChecks++;
         if (en_out !== expEn || out_7 !== expSeg || dp !== expDp) begin
            nFail++;
            $display("FAIL lzb_model: en=%h seg=%b want en=%h seg=%b", en_out, out_7, expEn, expSeg);
         end
         if (en_out !== 8'hFF) begin
            d = 0;
            for (int i = 0; i < 8; i++) if (en_out[i] == 1'b0) d = i;
            nChecks++;
            if (out_7 !== want[d]) begin
               nFail++;
               $display("FAIL lzb_digit: digit %0d seg=%b want %b", d, out_7, want[d]);
            end
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_capture_scan();
      test_freeze();
      test_tc_capture();
      test_async_reset();
`ifdef DISPLAY_LZB_EN
      test_lzb();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", nChecks, nFail);
      $finish;
   end

endmodule
